// File: rtl/exec_wb_seq.sv
// exec_wb_seq: multi-cycle execute/writeback sequencer for the 6-bit CPU.
// Takes one decoded instruction per handshake and walks it through
// IDLE -> READ -> EXEC -> WB, one cycle per state with no stalls.
// It is the only writer of the 5-entry register set.
// Because the next READ starts at least one cycle after the WB edge,
// back-to-back dependencies see the freshly written value without forwarding.

module exec_wb_seq #(
    parameter int NUM_REGS = 5,
    parameter int W        = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [2:0]   op,
    input  logic [2:0]   rd,
    input  logic [2:0]   rs1,
    input  logic [2:0]   rs2,
    input  logic [W-1:0] imm,
    output logic [2:0]   ra,
    output logic [2:0]   rb,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [2:0]   wr,
    output logic         we,
    output logic [W-1:0] wrd,
    output logic         zf,
    output logic         cf,
    output logic         done,
    output logic         err
);

    // Sequencer states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    // Opcode encodings
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_SHL1 = 3'd5;
    localparam logic [2:0] OP_LDI  = 3'd6;
    localparam logic [2:0] OP_MOV  = 3'd7;

    // Register count expressed in the width of a register index
    localparam logic [2:0] REG_LIMIT = 3'(NUM_REGS);

    logic [1:0]   state;
    logic [1:0]   state_next;

    logic [2:0]   op_q;
    logic [2:0]   rd_q;
    logic [W-1:0] imm_q;

    logic [W-1:0] op_a;
    logic [W-1:0] op_b;

    logic [W-1:0] result_q;
    logic         res_z_q;
    logic         res_c_q;

    logic [W-1:0] alu_r;
    logic         alu_c;
    logic [W:0]   sum_ext;
    logic [W:0]   diff_ext;

    logic         flags_z;
    logic         flags_c;

    logic         accept;
    logic         rd_legal;

    // Handshake and destination legality
    assign instr_ready = (state == S_IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign rd_legal    = (rd_q < REG_LIMIT);

    // Write port and status pulses exist only during WB
    assign wr   = rd_q;
    assign wrd  = result_q;
    assign we   = (state == S_WB) && rd_legal;
    assign err  = (state == S_WB) && !rd_legal;
    assign done = (state == S_WB);
    assign zf   = flags_z;
    assign cf   = flags_c;

    // Next-state: a fixed four-cycle walk, leaving IDLE only on accept
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = accept ? S_READ : S_IDLE;
            S_READ:  state_next = S_EXEC;
            S_EXEC:  state_next = S_WB;
            S_WB:    state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the instruction fields and read addresses on the accept edge only
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= '0;
            rd_q  <= '0;
            imm_q <= '0;
            ra    <= '0;
            rb    <= '0;
        end else if (accept) begin
            op_q  <= op;
            rd_q  <= rd;
            imm_q <= imm;
            ra    <= rs1;
            rb    <= rs2;
        end
    end

    // Capture the register-set read data at the end of READ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (state == S_READ) begin
            op_a <= a;
            op_b <= b;
        end
    end

    // ALU: extended add/subtract give carry and borrow in the top bit
    always_comb begin
        sum_ext  = {1'b0, op_a} + {1'b0, op_b};
        diff_ext = {1'b0, op_a} - {1'b0, op_b};
        alu_r    = '0;
        alu_c    = 1'b0;
        case (op_q)
            OP_ADD: begin
                alu_r = sum_ext[W-1:0];
                alu_c = sum_ext[W];
            end
            OP_SUB: begin
                alu_r = diff_ext[W-1:0];
                alu_c = diff_ext[W];
            end
            OP_AND:  alu_r = op_a & op_b;
            OP_OR:   alu_r = op_a | op_b;
            OP_XOR:  alu_r = op_a ^ op_b;
            OP_SHL1: begin
                alu_r = {op_a[W-2:0], 1'b0};
                alu_c = op_a[W-1];
            end
            OP_LDI:  alu_r = imm_q;
            OP_MOV:  alu_r = op_a;
            default: alu_r = '0;
        endcase
    end

    // Register the result and candidate flags at the end of EXEC
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            res_z_q  <= 1'b0;
            res_c_q  <= 1'b0;
        end else if (state == S_EXEC) begin
            result_q <= alu_r;
            res_z_q  <= (alu_r == '0);
            res_c_q  <= alu_c;
        end
    end

    // Architectural flags follow only legal writebacks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_z <= 1'b0;
            flags_c <= 1'b0;
        end else if ((state == S_WB) && rd_legal) begin
            flags_z <= res_z_q;
            flags_c <= res_c_q;
        end
    end

endmodule

// File: tb/tb_exec_wb_seq.sv
// tb_exec_wb_seq: directed and randomized checks of exec_wb_seq against a
// behavioural model of the architectural register file and flags.

module tb_exec_wb_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       instr_valid;
    logic       instr_ready;
    logic [2:0] op, rd, rs1, rs2;
    logic [5:0] imm;
    logic [2:0] ra, rb, wr;
    logic [5:0] a, b, wrd;
    logic       we, zf, cf, done, err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: indices 5-7 stay zero forever
    int mregs [8];
    int mzf = 0;
    int mcf = 0;
    logic [5:0] last_wrd;

    // Environment register set driven by the DUT write port
    logic [5:0] rf [0:4];

    exec_wb_seq #(.NUM_REGS(5), .W(6)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .ra(ra), .rb(rb), .a(a), .b(b),
        .wr(wr), .we(we), .wrd(wrd),
        .zf(zf), .cf(cf), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] readReg(input logic [2:0] idx);
        if (idx < 3'd5) return rf[idx];
        return 6'd0;
    endfunction

    assign a = readReg(ra);
    assign b = readReg(rb);

    // Register set writes on the edge that ends WB
    always @(posedge clk) begin
        if (we && (wr < 3'd5)) rf[wr] <= wrd;
    end

    // Reference ALU from plain arithmetic; returns {carry, result}
    function automatic logic [6:0] modelAlu(input int f_op, input int x, input int y, input int im);
        int r;
        int c;
        r = 0;
        c = 0;
        case (f_op)
            0: begin r = (x + y) % 64; c = ((x + y) > 63) ? 1 : 0; end
            1: begin r = (x - y + 64) % 64; c = (x < y) ? 1 : 0; end
            2: r = x & y;
            3: r = x | y;
            4: r = x ^ y;
            5: begin r = (x * 2) % 64; c = x / 32; end
            6: r = im;
            default: r = x;
        endcase
        return 7'(c * 64 + r);
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Run one instruction from an IDLE negedge through to the following IDLE negedge
    task automatic applyStimulus(input logic [2:0] f_op, input logic [2:0] f_rd,
                                 input logic [2:0] f_rs1, input logic [2:0] f_rs2,
                                 input logic [5:0] f_imm, input bit hold);
        logic [6:0] exp_cr;
        logic       legal;
        instr_valid = 1'b1;
        op  = f_op;
        rd  = f_rd;
        rs1 = f_rs1;
        rs2 = f_rs2;
        imm = f_imm;
        legal  = (f_rd < 3'd5);
        exp_cr = modelAlu(int'(f_op), mregs[f_rs1], mregs[f_rs2], int'(f_imm));
        checkOutput("ready_idle", 8'(instr_ready), 8'd1);

        @(negedge clk);
        if (hold) begin
            op = 3'($urandom); rd = 3'($urandom); rs1 = 3'($urandom);
            rs2 = 3'($urandom); imm = 6'($urandom);
        end else begin
            instr_valid = 1'b0;
        end
        checkOutput("ready_read", 8'(instr_ready), 8'd0);
        checkOutput("we_read", 8'(we), 8'd0);
        checkOutput("done_read", 8'(done), 8'd0);
        checkOutput("ra_read", 8'(ra), 8'(f_rs1));
        checkOutput("rb_read", 8'(rb), 8'(f_rs2));

        @(negedge clk);
        if (hold) begin
            op = 3'($urandom); rd = 3'($urandom); rs1 = 3'($urandom);
        end
        checkOutput("ready_exec", 8'(instr_ready), 8'd0);
        checkOutput("we_exec", 8'(we), 8'd0);
        checkOutput("err_exec", 8'(err), 8'd0);

        @(negedge clk);
        checkOutput("ready_wb", 8'(instr_ready), 8'd0);
        checkOutput("we_wb", 8'(we), 8'(legal));
        checkOutput("err_wb", 8'(err), 8'(!legal));
        checkOutput("done_wb", 8'(done), 8'd1);
        checkOutput("wr_wb", 8'(wr), 8'(f_rd));
        checkOutput("wrd_wb", 8'(wrd), 8'(exp_cr[5:0]));
        checkOutput("ra_wb", 8'(ra), 8'(f_rs1));
        last_wrd = wrd;
        if (legal) begin
            mregs[f_rd] = int'(exp_cr[5:0]);
            mzf = (exp_cr[5:0] == 6'd0) ? 1 : 0;
            mcf = int'(exp_cr[6]);
        end

        @(negedge clk);
        checkOutput("zf_after", 8'(zf), 8'(mzf));
        checkOutput("cf_after", 8'(cf), 8'(mcf));
        checkOutput("we_after", 8'(we), 8'd0);
        checkOutput("done_after", 8'(done), 8'd0);
        checkOutput("err_after", 8'(err), 8'd0);
        checkOutput("ready_after", 8'(instr_ready), 8'd1);
    endtask

    // Main directed sequence followed by a randomized stretch
    initial begin
        for (int i = 0; i < 5; i++) rf[i] = 6'd0;
        for (int i = 0; i < 8; i++) mregs[i] = 0;
        instr_valid = 1'b0;
        op = 3'd0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0; imm = 6'd0;
        last_wrd = 6'd0;

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 8'(instr_ready), 8'd0);
        checkOutput("rst_we", 8'(we), 8'd0);
        checkOutput("rst_done", 8'(done), 8'd0);
        checkOutput("rst_err", 8'(err), 8'd0);
        checkOutput("rst_ra", 8'(ra), 8'd0);
        checkOutput("rst_wrd", 8'(wrd), 8'd0);
        checkOutput("rst_zf", 8'(zf), 8'd0);
        checkOutput("rst_cf", 8'(cf), 8'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] directed LDI / ADD / SUB / SHL1 / MOV");
        applyStimulus(3'd6, 3'd2, 3'd0, 3'd0, 6'h2A, 1'b0);
        checkOutput("plan_ldi_wrd", 8'(last_wrd), 8'h2A);
        applyStimulus(3'd6, 3'd1, 3'd0, 3'd0, 6'h3F, 1'b0);
        applyStimulus(3'd6, 3'd2, 3'd0, 3'd0, 6'h01, 1'b0);
        applyStimulus(3'd0, 3'd3, 3'd1, 3'd2, 6'h00, 1'b0);
        checkOutput("plan_add_wrd", 8'(last_wrd), 8'h00);
        checkOutput("plan_add_zf", 8'(zf), 8'd1);
        checkOutput("plan_add_cf", 8'(cf), 8'd1);
        applyStimulus(3'd1, 3'd4, 3'd2, 3'd1, 6'h00, 1'b0);
        checkOutput("plan_sub_wrd", 8'(last_wrd), 8'h02);
        checkOutput("plan_sub_zf", 8'(zf), 8'd0);
        checkOutput("plan_sub_cf", 8'(cf), 8'd1);
        applyStimulus(3'd5, 3'd0, 3'd1, 3'd0, 6'h00, 1'b0);
        checkOutput("plan_shl_wrd", 8'(last_wrd), 8'h3E);
        checkOutput("plan_shl_cf", 8'(cf), 8'd1);
        applyStimulus(3'd7, 3'd1, 3'd0, 3'd0, 6'h00, 1'b0);
        checkOutput("plan_mov_wrd", 8'(last_wrd), 8'h3E);

        $display("[TB] illegal destination");
        applyStimulus(3'd6, 3'd6, 3'd0, 3'd0, 6'h15, 1'b0);
        checkOutput("plan_err_zf", 8'(zf), 8'd0);
        checkOutput("plan_err_cf", 8'(cf), 8'd0);
        for (int i = 0; i < 5; i++) checkOutput("plan_err_regs", 8'(rf[i]), 8'(mregs[i]));

        $display("[TB] instr_valid held for three instructions");
        applyStimulus(3'd6, 3'd4, 3'd0, 3'd0, 6'h11, 1'b1);
        applyStimulus(3'd0, 3'd3, 3'd4, 3'd4, 6'h00, 1'b1);
        applyStimulus(3'd4, 3'd2, 3'd3, 3'd1, 6'h00, 1'b1);
        instr_valid = 1'b0;

        $display("[TB] randomized instructions");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(3'($urandom), 3'($urandom), 3'($urandom_range(0, 7)),
                          3'($urandom_range(0, 7)), 6'($urandom), 1'b0);
        end

        $display("[TB] reset during EXEC");
        applyStimulus(3'd6, 3'd0, 3'd0, 3'd0, 6'h00, 1'b0);
        checkOutput("pre_rst_zf", 8'(zf), 8'd1);
        instr_valid = 1'b1;
        op = 3'd0; rd = 3'd1; rs1 = 3'd2; rs2 = 3'd3; imm = 6'd0;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_we", 8'(we), 8'd0);
        checkOutput("mid_rst_done", 8'(done), 8'd0);
        checkOutput("mid_rst_ready", 8'(instr_ready), 8'd0);
        checkOutput("mid_rst_ra", 8'(ra), 8'd0);
        checkOutput("mid_rst_rb", 8'(rb), 8'd0);
        checkOutput("mid_rst_wrd", 8'(wrd), 8'd0);
        checkOutput("mid_rst_zf", 8'(zf), 8'd0);
        checkOutput("mid_rst_cf", 8'(cf), 8'd0);
        mzf = 0;
        mcf = 0;
        @(negedge clk);
        checkOutput("mid_rst_we_hold", 8'(we), 8'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 8'(instr_ready), 8'd1);
        checkOutput("post_rst_we", 8'(we), 8'd0);
        checkOutput("post_rst_r1", 8'(rf[1]), 8'(mregs[1]));

        applyStimulus(3'd7, 3'd4, 3'd1, 3'd0, 6'h00, 1'b0);
        for (int i = 0; i < 5; i++) checkOutput("final_regs", 8'(rf[i]), 8'(mregs[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
